cp0_exception_unit: RTL
=======================

# cp0_exception_unit

Coprocessor-0 block for the five-stage MIPS pipeline. It sits beside the M stage, collects the exception code and branch-delay flag carried down the pipe plus the six external hardware interrupt lines, and raises the single-cycle request `Req`. `Req` flushes every pipeline register, loads W with the handler address 0x0000_4180, and redirects fetch. It holds SR, Cause, EPC and PRId, serves `mfc0`/`mtc0`, and supplies EPC for `eret`.

## Interface
- `PRID`, default 32'h2206_0007, value returned when reading register 15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `en`  in  1  `mtc0` write strobe from M.
- `CP0Add`  in  5  register number for both read and write.
- `CP0In`  in  32  `mtc0` write data.
- `VPC`  in  32  PC of the instruction currently in M.
- `BDIn`  in  1  M instruction is in a branch delay slot.
- `ExcCodeIn`  in  5  exception code of the M instruction; 0 means none.
- `HWInt`  in  6  external interrupt lines, level-sensitive.
- `EXLClr`  in  1  `eret` in M.
- `CP0Out`  out  32  read data for `CP0Add`, combinational.
- `EPCOut`  out  32  current EPC, combinational.
- `Req`  out  1  exception/interrupt taken this cycle, combinational.

## Operation
- SR (12): IM = bits [15:10], EXL = bit 1, IE = bit 0. All other bits read 0.
- Cause (13): BD = bit 31, IP = bits [15:10], ExcCode = bits [6:2]. All other bits read 0.
- EPC (14): 32 bits.
- PRId (15): constant `PRID`.
- Any other address reads 0.
- Interrupt pending: `IntReq = IE & ~EXL & |(HWInt & IM)`.
- Exception pending: `ExcReq = (ExcCodeIn != 0) & ~EXL`.
- `Req = IntReq | ExcReq`. An interrupt has priority over an exception in the same cycle.
- On a cycle with `Req` high, at the edge:
  - EXL <= 1.
  - Cause.BD <= BDIn.
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn.
  - EPC <= BDIn ? {VPC[31:2],2'b00} - 4 : {VPC[31:2],2'b00}. Subtraction is mod 2^32.
- Cause.IP <= HWInt every cycle, regardless of `Req` or EXL.
- `mtc0` (`en` high, `Req` low):
  - Address 12 writes IM, EXL and IE from the matching bits of `CP0In`.
  - Address 14 writes all 32 bits of EPC.
  - Addresses 13, 15 and others: write ignored.
- `EXLClr` high with `Req` low: EXL <= 0 at the edge.
- Priority at the edge, highest first: `reset` > `Req` > `mtc0` > `EXLClr`.
  - When `en` writes SR while `EXLClr` is high, EXL takes the written value, then is cleared by `EXLClr`. Net result: EXL = 0, IM and IE written.
- While EXL = 1, `Req` stays 0 whatever the inputs are. There are no nested exceptions.

## Timing
- Reset values:
  - SR = 0, Cause = 0, EPC = 0.
  - `Req` = 0 (IE = 0, EXL = 0, no exception presented).
  - `EPCOut` = 0; `CP0Out` = 0 for address 12, 13 or 14.
- `Req`, `CP0Out` and `EPCOut` have zero latency. They reflect current register state and current inputs.
- Register writes become visible on `CP0Out` the cycle after the edge. There is no write-to-read bypass.
- `Req` lasts exactly one cycle: the edge that samples it sets EXL, which gates it off. A persistent `HWInt` does not retrigger until EXL is cleared and IE/IM allow it.
- Cause.IP has a one-cycle lag from `HWInt`. `Req` uses live `HWInt`.
- `reset` asserted mid-exception (`Req` high in the same cycle) takes priority: all state is 0 after the edge, and EPC is not captured.

## Test plan
- Reset, then read addresses 12, 13, 14, 15, 20:
  - -> 0, 0, 0, 0x2206_0007, 0; `Req` = 0.
- `mtc0` 12 ← 0x0000_FC01, then `HWInt` = 6'b000100, VPC = 0x0000_3010, BDIn = 0:
  - -> `Req` = 1 for one cycle.
  - -> After the edge: EPC = 0x3010, Cause = 0x0000_1000 (IP bit 12 set, ExcCode 0, BD 0), SR = 0x0000_FC03.
  - -> `Req` = 0 next cycle while `HWInt` stays high.
- IE = 0, ExcCodeIn = 12 (Ov), VPC = 0x0000_3024, BDIn = 1:
  - -> `Req` = 1; EPC = 0x3020, Cause.BD = 1, Cause.ExcCode = 12.
- `HWInt` asserted and ExcCodeIn = 10 in the same cycle, with IE = 1 and IM enabled:
  - -> Cause.ExcCode = 0 (interrupt wins), EPC = VPC.
- While EXL = 1, present ExcCodeIn = 4:
  - -> `Req` stays 0.
  - -> Then `EXLClr` for one cycle: SR.EXL = 0 next cycle, and the still-present ExcCodeIn = 4 raises `Req`.
- `en` = 1 at address 14 with data 0x0000_5000 in the same cycle as an exception:
  - -> EPC = VPC, not 0x5000.
- `en` = 1 at address 13:
  - -> Cause is unchanged.

Source files
------------

// File: rtl/cp0_exception_unit.sv
// -----------------------------------------------------------------------------
// cp0_exception_unit
//
// Coprocessor-0 for the five-stage MIPS pipeline, sitting beside the M stage.
// It holds SR, Cause, EPC and PRId, serves mfc0/mtc0, supplies EPC for eret,
// and raises the single-cycle request Req that flushes the pipe and redirects
// fetch to the exception handler.
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous, active-high; clears all state
//   en         in   1   mtc0 write strobe from M
//   CP0Add     in   5   register number for read and write
//   CP0In      in  32   mtc0 write data
//   VPC        in  32   PC of the instruction in M
//   BDIn       in   1   M instruction sits in a branch delay slot
//   ExcCodeIn  in   5   exception code of the M instruction (0 = none)
//   HWInt      in   6   external interrupt lines, level-sensitive
//   EXLClr     in   1   eret in M
//   CP0Out     out 32   read data for CP0Add (combinational)
//   EPCOut     out 32   current EPC (combinational)
//   Req        out  1   exception/interrupt taken this cycle (combinational)
// -----------------------------------------------------------------------------
module cp0_exception_unit #(
    parameter logic [31:0] PRID = 32'h2206_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] CP0Out,
    output logic [31:0] EPCOut,
    output logic        Req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // SR fields
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    // Cause fields
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    // EPC
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_aligned;
    logic [31:0] epc_next;

    // EXL masks both sources, so Req drops the cycle after it is taken and
    // no nested exception can ever be raised.
    assign int_req = ie & ~exl & (|(HWInt & im));
    assign exc_req = (ExcCodeIn != 5'd0) & ~exl;
    assign Req     = int_req | exc_req;

    // A delay-slot instruction restarts at its branch, one word earlier.
    assign pc_aligned = {VPC[31:2], 2'b00};
    assign epc_next   = BDIn ? (pc_aligned - 32'd4) : pc_aligned;

    assign EPCOut = epc;

    always_comb begin
        // NOTE: default assignment before the case keeps this purely
        // combinational; a missing path would otherwise infer a latch.
        CP0Out = 32'd0;
        case (CP0Add)
            ADDR_SR:    CP0Out = {16'd0, im, 8'd0, exl, ie};
            ADDR_CAUSE: CP0Out = {bd, 15'd0, ip, 3'd0, exc_code, 2'b00};
            ADDR_EPC:   CP0Out = epc;
            ADDR_PRID:  CP0Out = PRID;
            default:    CP0Out = 32'd0;
        endcase
    end

    // NOTE: non-blocking assignments for all state so every register sees
    // the pre-edge values; later assignments in the block override earlier
    // ones, which is how EXLClr beats a same-cycle mtc0 to SR.EXL.
    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= 6'd0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            // Pending lines are sampled every cycle, independent of Req/EXL.
            ip <= HWInt;
            if (Req) begin
                exl      <= 1'b1;
                bd       <= BDIn;
                exc_code <= int_req ? 5'd0 : ExcCodeIn;
                epc      <= epc_next;
            end else begin
                if (en && (CP0Add == ADDR_SR)) begin
                    im  <= CP0In[15:10];
                    exl <= CP0In[1];
                    ie  <= CP0In[0];
                end
                if (en && (CP0Add == ADDR_EPC)) begin
                    epc <= CP0In;
                end
                if (EXLClr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

endmodule
